hdmi_frame_reader: RTL and testbench
====================================

Name: hdmi_frame_reader

Overview:
- Stage directly upstream of the HDMI output top. Converts the 32-bit DDR read-FIFO stream into the 16-bit RGB565 pixel stream that the top requests with O_Pre_De.
- Paces FIFO reads on demand, with a fixed 1-cycle request-to-data latency.
- Issues a per-frame start request to the DDR read controller on each V-sync.
- Detects FIFO underflow and blanks the rest of that frame.

Parameters:
H_ActiveSize, 1280, active pixels per line; must be even
V_ActiveSize, 1024, active lines per frame
BLANK_COLOR, 16'h0000, RGB565 value driven during underflow or while not streaming

Ports:
Pixl_CLK  in  1  pixel clock; only clock
Rst_Posedge  in  1  reset; synchronous, active-high
I_Pre_De  in  1  pixel request from HDMI top (its O_Pre_De)
I_VGA_Sync  in  1  V-sync from HDMI top (its O_VGA_Sync), active-high
O_Post_De  out  1  pixel valid to HDMI top (its I_Post_De)
O_Pixel_Data  out  16  RGB565 pixel to HDMI top (its I_Pixel_Data)
O_Fifo_Rd_En  out  1  read strobe to read FIFO; data appears on I_Fifo_Dout 1 cycle later
I_Fifo_Dout  in  32  two pixels per word; [15:0] displayed first
I_Fifo_Empty  in  1  read FIFO empty
O_Frame_Start  out  1  1-cycle pulse telling the DDR read controller to start the next frame
O_Frame_Done  out  1  1-cycle pulse when the last pixel of a frame has been output
O_Underflow  out  1  sticky; set on any underflow, cleared only by reset
O_Underflow_Cnt  out  16  count of frames with underflow; saturates at 16'hFFFF

Behaviour:
- Reset values: all outputs 0; O_Pixel_Data = BLANK_COLOR; state = WAIT_VS.
- V-sync rise: detected as I_VGA_Sync high while its registered copy is low. Rise is the only frame boundary.
- States:
  - WAIT_VS: on V-sync rise, pulse O_Frame_Start, clear the pixel counter (21 bits), go to FILL.
  - FILL: when I_Fifo_Empty = 0, assert O_Fifo_Rd_En for 1 cycle, go to PRIME.
  - PRIME: latch I_Fifo_Dout into word_reg, set half = 0, go to STREAM.
  - STREAM: per I_Pre_De cycle, output the selected half, then toggle half.
    - When half = 1 is consumed, issue O_Fifo_Rd_En for the next word if pixels remain and FIFO not empty.
    - When that read was issued in the previous cycle (rd_vld), the low half comes straight from I_Fifo_Dout, which is also latched into word_reg.
  - BLANK: entered on underflow; outputs BLANK_COLOR for every I_Pre_De until the next V-sync rise, then behaves as WAIT_VS.
- Latency: O_Post_De(t+1) = I_Pre_De(t) in every state. O_Pixel_Data is registered, valid with O_Post_De, and BLANK_COLOR whenever O_Post_De = 0.
- Underflow is either of:
  - a next-word read is needed but I_Fifo_Empty = 1;
  - I_Pre_De arrives in FILL or PRIME.
  - Response: set O_Underflow, increment O_Underflow_Cnt once per frame, output BLANK_COLOR for that pixel, go to BLANK.
- End of frame: after H_ActiveSize*V_ActiveSize pixels, pulse O_Frame_Done with the last O_Post_De, issue no further reads, go to WAIT_VS. Extra I_Pre_De in WAIT_VS outputs BLANK_COLOR and is not an underflow.
- V-sync rise in FILL/PRIME/STREAM/BLANK (short frame): abort, pulse O_Frame_Start, restart at FILL. Any in-flight read is discarded; words left in the FIFO are flushed by the controller on O_Frame_Start.
- O_Frame_Start and O_Frame_Done in the same cycle: both assert.
- Reset asserted mid-frame: all state and outputs return to reset values on the next edge; no read is issued while reset is high.

Decomposition:
- Shared package holds: state encoding (WAIT_VS, FILL, PRIME, STREAM, BLANK); PIX_CNT_W = 21; RGB565 field widths.
- One sub-module: hdmi_word_unpack (word_reg, half toggle, fresh/registered source mux). FSM, counters and status stay in the top.

Test Plan:
- H=8, V=4, FIFO preloaded with 16 words 0x0001_0000..0x001F_001E; V-sync rise then 32 DE -> O_Pixel_Data 0x0000,0x0001,…,0x001F, each exactly 1 cycle after its DE; one O_Frame_Start; O_Frame_Done with pixel 31.
- Same frame with I_Pre_De gapped (1 on, 2 off) -> identical pixel sequence; O_Fifo_Rd_En count = 16.
- FIFO holds only 5 words -> pixels 0..9 correct, pixel 10 onward BLANK_COLOR; O_Underflow = 1; O_Underflow_Cnt = 1; next frame with a full FIFO streams correctly and the count stays 1.
- V-sync rise after 20 of 32 pixels -> O_Frame_Start pulses again; next frame starts at the first new FIFO word; no O_Frame_Done for the aborted frame.
- Rst_Posedge high for 1 cycle mid-STREAM -> outputs return to reset values next cycle; no O_Fifo_Rd_En until after the next V-sync rise.
- Back-to-back frames with O_Underflow_Cnt forced near 16'hFFFF and every frame underflowing -> count holds at 16'hFFFF.

Source files
------------

// File: rtl/hdmi_frame_reader_pkg.sv
// Shared types and widths for the HDMI frame reader: FSM encoding, pixel counter width, RGB565 layout.
package hdmi_frame_reader_pkg;

    typedef enum logic [2:0] {
        WAIT_VS = 3'd0,
        FILL    = 3'd1,
        PRIME   = 3'd2,
        STREAM  = 3'd3,
        BLANK   = 3'd4
    } rd_state_e;

    localparam int PIX_CNT_W = 21;

    localparam int RGB_R_W = 5;
    localparam int RGB_G_W = 6;
    localparam int RGB_B_W = 5;
    localparam int RGB_W   = RGB_R_W + RGB_G_W + RGB_B_W;

endpackage

// File: rtl/hdmi_word_unpack.sv
// Splits 32-bit FIFO words into two RGB565 pixels, low half first; pixel select is combinational.
// A word read in the previous cycle is used straight from the FIFO output and latched at the same time.
module hdmi_word_unpack
    import hdmi_frame_reader_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               load_i,
    input  logic               consume_i,
    input  logic               rd_vld_i,
    input  logic [2*RGB_W-1:0] word_i,
    output logic [RGB_W-1:0]   pix_o,
    output logic               half_o
);

    logic [2*RGB_W-1:0] word_q;
    logic               half_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            word_q <= '0;
            half_q <= 1'b0;
        end else begin
            if (load_i || rd_vld_i) begin
                word_q <= word_i;
            end
            if (load_i) begin
                half_q <= 1'b0;
            end else if (consume_i) begin
                half_q <= ~half_q;
            end
        end
    end

    // rd_vld only ever follows a high-half consume, so half_q is 0 here.
    assign pix_o  = rd_vld_i ? word_i[RGB_W-1:0]
                  : (half_q ? word_q[2*RGB_W-1:RGB_W] : word_q[RGB_W-1:0]);
    assign half_o = half_q;

endmodule

// File: rtl/hdmi_frame_reader.sv
// Turns the 32-bit DDR read-FIFO stream into 16-bit pixels on demand; O_Post_De/O_Pixel_Data follow I_Pre_De by 1 cycle.
// FIFO reads are paced by I_Pre_De (1-cycle read latency); a FIFO that cannot keep up blanks the rest of the frame.
module hdmi_frame_reader
    import hdmi_frame_reader_pkg::*;
#(
    parameter int               H_ActiveSize = 1280,
    parameter int               V_ActiveSize = 1024,
    parameter logic [RGB_W-1:0] BLANK_COLOR  = 16'h0000
) (
    input  logic                 Pixl_CLK,
    input  logic                 Rst_Posedge,
    input  logic                 I_Pre_De,
    input  logic                 I_VGA_Sync,
    output logic                 O_Post_De,
    output logic [RGB_W-1:0]     O_Pixel_Data,
    output logic                 O_Fifo_Rd_En,
    input  logic [2*RGB_W-1:0]   I_Fifo_Dout,
    input  logic                 I_Fifo_Empty,
    output logic                 O_Frame_Start,
    output logic                 O_Frame_Done,
    output logic                 O_Underflow,
    output logic [15:0]          O_Underflow_Cnt
);

    localparam logic [PIX_CNT_W-1:0] LAST_PIX = PIX_CNT_W'(H_ActiveSize * V_ActiveSize - 1);

    rd_state_e            state_q;
    logic                 vs_q;
    logic                 rd_vld_q;
    logic [PIX_CNT_W-1:0] pix_cnt_q;
    logic [15:0]          ufl_cnt_q;
    logic [15:0]          ufl_cnt_d;
    logic [RGB_W-1:0]     pix_w;
    logic                 half_w;
    logic                 vs_rise;
    logic                 pix_take;
    logic                 last_pix;
    logic                 need_rd;
    logic                 fill_rd;
    logic                 stream_rd;
    logic                 underflow;

    assign vs_rise   = I_VGA_Sync & ~vs_q;
    assign pix_take  = (state_q == STREAM) & I_Pre_De;
    assign last_pix  = (pix_cnt_q == LAST_PIX);
    assign need_rd   = pix_take & half_w & ~last_pix;
    // The first read waits out the O_Frame_Start cycle so the controller's flush lands first.
    assign fill_rd   = (state_q == FILL) & ~I_Pre_De & ~I_Fifo_Empty & ~O_Frame_Start;
    assign stream_rd = need_rd & ~I_Fifo_Empty;

    assign O_Fifo_Rd_En = ~Rst_Posedge & ~vs_rise & (fill_rd | stream_rd);

    assign underflow = ~vs_rise & ((need_rd & I_Fifo_Empty) |
                                   (I_Pre_De & ((state_q == FILL) || (state_q == PRIME))));

    assign ufl_cnt_d = (underflow && (ufl_cnt_q != 16'hFFFF)) ? ufl_cnt_q + 16'd1 : ufl_cnt_q;
    assign O_Underflow_Cnt = ufl_cnt_q;

    hdmi_word_unpack u_unpack (
        .clk_i     (Pixl_CLK),
        .rst_i     (Rst_Posedge),
        .load_i    (state_q == PRIME),
        .consume_i (pix_take),
        .rd_vld_i  (rd_vld_q),
        .word_i    (I_Fifo_Dout),
        .pix_o     (pix_w),
        .half_o    (half_w)
    );

    always_ff @(posedge Pixl_CLK) begin
        if (Rst_Posedge) begin
            state_q       <= WAIT_VS;
            vs_q          <= 1'b0;
            rd_vld_q      <= 1'b0;
            pix_cnt_q     <= '0;
            ufl_cnt_q     <= '0;
            O_Post_De     <= 1'b0;
            O_Pixel_Data  <= BLANK_COLOR;
            O_Frame_Start <= 1'b0;
            O_Frame_Done  <= 1'b0;
            O_Underflow   <= 1'b0;
        end else begin
            vs_q          <= I_VGA_Sync;
            rd_vld_q      <= stream_rd & ~vs_rise;
            ufl_cnt_q     <= ufl_cnt_d;
            O_Post_De     <= I_Pre_De;
            O_Pixel_Data  <= pix_take ? pix_w : BLANK_COLOR;
            O_Frame_Start <= 1'b0;
            O_Frame_Done  <= pix_take & last_pix;
            if (pix_take) begin
                pix_cnt_q <= pix_cnt_q + 1'b1;
            end
            if (underflow) begin
                O_Underflow <= 1'b1;
            end

            case (state_q)
                FILL:    if (fill_rd) state_q <= PRIME;
                PRIME:   state_q <= STREAM;
                STREAM:  if (pix_take && last_pix) state_q <= WAIT_VS;
                default: ;
            endcase

            if (underflow) begin
                state_q <= BLANK;
            end
            // A V-sync rise always starts a new frame, aborting whatever was in progress.
            if (vs_rise) begin
                state_q       <= FILL;
                O_Frame_Start <= 1'b1;
                pix_cnt_q     <= '0;
            end
        end
    end

endmodule

// File: tb/tb_hdmi_frame_reader.sv
// Randomized bench for hdmi_frame_reader: a FIFO/controller environment plus a pixel-queue reference model.
module tb_hdmi_frame_reader;

    localparam int          H     = 8;
    localparam int          V     = 4;
    localparam int          TOTAL = H * V;
    localparam logic [15:0] BLANK = 16'h0000;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        de_i = 1'b0;
    logic        vs_i = 1'b0;
    logic        empty_i = 1'b1;
    logic [31:0] dout_i = 32'h0;
    logic        post_de, rd_en, fstart, fdone, ufl;
    logic [15:0] pix, ucnt;

    always #5 clk = ~clk;

    hdmi_frame_reader #(
        .H_ActiveSize (H),
        .V_ActiveSize (V),
        .BLANK_COLOR  (BLANK)
    ) dut (
        .Pixl_CLK        (clk),
        .Rst_Posedge     (rst_i),
        .I_Pre_De        (de_i),
        .I_VGA_Sync      (vs_i),
        .O_Post_De       (post_de),
        .O_Pixel_Data    (pix),
        .O_Fifo_Rd_En    (rd_en),
        .I_Fifo_Dout     (dout_i),
        .I_Fifo_Empty    (empty_i),
        .O_Frame_Start   (fstart),
        .O_Frame_Done    (fdone),
        .O_Underflow     (ufl),
        .O_Underflow_Cnt (ucnt)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Environment: read FIFO plus a controller that reloads it whenever O_Frame_Start pulses.
    logic [31:0] fq[$];
    int          next_words = 16;
    logic [15:0] base = 16'h0000;
    bit          env_rd = 0, env_start = 0;
    int          cnt_rd, cnt_start, cnt_done;
    logic [15:0] got[$];

    // Reference model: pixels fetched but not yet shown sit in a queue.
    typedef enum int {M_IDLE, M_FILL, M_PRIME, M_RUN, M_BLANK} mmode_e;
    mmode_e      m_mode = M_IDLE;
    int          m_pix = 0;
    logic [15:0] m_pq[$];
    bit          m_infl = 0;
    logic [31:0] m_word = 32'h0;
    bit          m_vs = 0;
    bit          e_de = 0, e_start = 0, e_done = 0, e_ufl = 0, e_rd = 0;
    logic [15:0] e_pix = BLANK;
    logic [15:0] e_cnt = 16'h0;

    task automatic model_step();
        bit          rise, ev, n_done;
        logic [15:0] p;
        if (rst_i) begin
            m_mode = M_IDLE; m_pix = 0; m_pq.delete(); m_infl = 0; m_vs = 0;
            e_de = 0; e_pix = BLANK; e_start = 0; e_done = 0; e_ufl = 0; e_cnt = 0; e_rd = 0;
            return;
        end
        rise = vs_i && !m_vs;
        m_vs = vs_i;
        if (m_infl) begin
            m_pq.push_back(m_word[15:0]);
            m_pq.push_back(m_word[31:16]);
            m_infl = 0;
        end
        p = BLANK; ev = 0; n_done = 0; e_rd = 0;
        case (m_mode)
            M_FILL: begin
                if (de_i) ev = 1;
                else if (!empty_i && !e_start && !rise) begin
                    e_rd = 1; m_word = fq[0]; m_infl = 1; m_mode = M_PRIME;
                end
            end
            M_PRIME: begin
                if (de_i) ev = 1;
                else m_mode = M_RUN;
            end
            M_RUN: begin
                if (de_i && m_pq.size() > 0) begin
                    p = m_pq.pop_front();
                    m_pix++;
                    if (m_pix == TOTAL) begin
                        n_done = 1; m_mode = M_IDLE;
                    end else if (m_pq.size() == 0 && !rise) begin
                        if (empty_i) ev = 1;
                        else begin e_rd = 1; m_word = fq[0]; m_infl = 1; end
                    end
                end
            end
            default: ;
        endcase
        if (ev && !rise) begin
            e_ufl = 1;
            if (e_cnt != 16'hFFFF) e_cnt++;
            m_mode = M_BLANK; m_pq.delete(); m_infl = 0;
        end
        if (rise) begin
            m_mode = M_FILL; m_pix = 0; m_pq.delete(); m_infl = 0;
        end
        e_start = rise; e_done = n_done; e_de = de_i; e_pix = p;
    endtask

    task automatic cyc(input bit de, input bit vs, input bit rst);
        @(posedge clk);
        #1;
        if (env_rd) begin
            if (fq.size() > 0) dout_i = fq.pop_front();
            else dout_i = 32'hDEAD_BEEF;
        end
        if (env_start) begin
            fq.delete();
            for (int k = 0; k < next_words; k++)
                fq.push_back({base + 16'(2 * k + 1), base + 16'(2 * k)});
            base += 16'h0040;
        end
        empty_i = (fq.size() == 0);
        de_i = de; vs_i = vs; rst_i = rst;
        @(negedge clk);
        check_val("post_de", post_de, e_de);
        check_val("pixel", pix, e_pix);
        check_val("frame_start", fstart, e_start);
        check_val("frame_done", fdone, e_done);
        check_val("underflow", ufl, e_ufl);
        check_val("ufl_cnt", ucnt, e_cnt);
        model_step();
        check_val("rd_en", rd_en, e_rd);
        env_rd = rd_en; env_start = fstart;
        if (rd_en) cnt_rd++;
        if (fstart) cnt_start++;
        if (fdone) cnt_done++;
        if (post_de) got.push_back(pix);
    endtask

    // gap < 0 picks a random 0..2 cycle gap after each DE; rst_at >= 0 injects a reset before that pixel.
    task automatic run_frame(input int nwords, input int gap, input int idle, input int npix, input int rst_at);
        int g;
        next_words = nwords;
        got.delete(); cnt_rd = 0; cnt_start = 0; cnt_done = 0;
        cyc(0, 1, 0);
        cyc(0, 1, 0);
        repeat (idle) cyc(0, 0, 0);
        for (int p = 0; p < npix; p++) begin
            if (p == rst_at) begin
                cyc(0, 0, 1);
                cnt_rd = 0;
            end
            cyc(1, 0, 0);
            g = (gap < 0) ? int'($urandom_range(2, 0)) : gap;
            repeat (g) cyc(0, 0, 0);
        end
        repeat (3) cyc(0, 0, 0);
    endtask

    function automatic logic [15:0] got_at(input int i);
        if (i < got.size()) return got[i];
        return 16'hxxxx;
    endfunction

    initial begin
        repeat (3) cyc(0, 0, 1);
        cyc(0, 0, 0);
        check_val("reset_ufl_cnt", ucnt, 0);
        check_val("reset_pixel", pix, BLANK);

        // Full frame, back-to-back DE, two stray DEs afterwards.
        run_frame(16, 0, 5, 34, -1);
        check_val("t1_starts", cnt_start, 1);
        check_val("t1_dones", cnt_done, 1);
        check_val("t1_reads", cnt_rd, 16);
        check_val("t1_npix", got.size(), 34);
        for (int i = 0; i < 32; i++) check_val("t1_pix", got_at(i), i);
        check_val("t1_extra0", got_at(32), BLANK);
        check_val("t1_extra1", got_at(33), BLANK);
        check_val("t1_ufl", ufl, 0);

        // Gapped DE (1 on, 2 off).
        run_frame(16, 2, 5, 32, -1);
        check_val("t2_reads", cnt_rd, 16);
        check_val("t2_dones", cnt_done, 1);
        for (int i = 0; i < 32; i++) check_val("t2_pix", got_at(i), 16'h0040 + 16'(i));

        // Only five words available.
        run_frame(5, 0, 5, 32, -1);
        for (int i = 0; i < 32; i++)
            check_val("t3_pix", got_at(i), (i < 10) ? 16'h0080 + 16'(i) : BLANK);
        check_val("t3_ufl", ufl, 1);
        check_val("t3_ufl_cnt", ucnt, 1);
        check_val("t3_dones", cnt_done, 0);
        run_frame(16, -1, 5, 32, -1);
        for (int i = 0; i < 32; i++) check_val("t3b_pix", got_at(i), 16'h00C0 + 16'(i));
        check_val("t3b_ufl_cnt", ucnt, 1);

        // Short frame aborted by the next V-sync.
        run_frame(16, 0, 5, 20, -1);
        check_val("t4_abort_dones", cnt_done, 0);
        run_frame(16, 0, 5, 32, -1);
        check_val("t4_starts", cnt_start, 1);
        check_val("t4_first_pix", got_at(0), 16'h0140);
        check_val("t4_dones", cnt_done, 1);

        // Reset in the middle of streaming.
        run_frame(16, 0, 5, 20, 10);
        check_val("t5_reads_after_rst", cnt_rd, 0);
        check_val("t5_ufl", ufl, 0);
        check_val("t5_ufl_cnt", ucnt, 0);
        check_val("t5_dones", cnt_done, 0);
        run_frame(16, -1, 5, 32, -1);
        check_val("t5_recover_dones", cnt_done, 1);

        for (int f = 0; f < 25; f++) begin
            int nw, id, np, ra;
            nw = int'($urandom_range(16, 0));
            id = int'($urandom_range(6, 0));
            np = int'($urandom_range(32, 1));
            ra = ($urandom_range(7, 0) == 0) ? int'($urandom_range(15, 0)) : -1;
            run_frame(nw, -1, id, np, ra);
        end

        // Saturation: preset the counter near the top, then underflow every frame.
        force dut.ufl_cnt_q = 16'hFFFD;
        e_cnt = 16'hFFFD;
        cyc(0, 0, 0);
        release dut.ufl_cnt_q;
        for (int f = 0; f < 4; f++) run_frame(0, 0, 5, 8, -1);
        check_val("t6_ufl_cnt_sat", ucnt, 16'hFFFF);
        check_val("t6_ufl", ufl, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
